bram_rmw_requester: RTL and testbench
=====================================

Name: bram_rmw_requester

Overview:
- Client-side controller for one port of the team's one-cycle true dual-port block RAM.
- Accepts word requests from a core-side valid/ready bus, each with per-byte write strobes, and drives the RAM port's ADDR/DI/WE/RE/EN signals.
- Consumes the RAM's DO and DO_VALID and returns responses on a valid/ready response channel.
- The RAM writes whole words only, so partial-strobe writes are done as read-modify-write.

Parameters:
- DATA_WIDTH, 32, word width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 10, word address width. Matches the RAM instance.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request ready. Forced 0 while RST_N is low.
- REQ_ADDR  in  ADDR_WIDTH  word address.
- REQ_WRITE  in  1  1 = write, 0 = read.
- REQ_WDATA  in  DATA_WIDTH  write data.
- REQ_STRB  in  DATA_WIDTH/8  byte strobes. Ignored for reads.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response ready.
- RSP_RDATA  out  DATA_WIDTH  read data, or the merged word written.
- RSP_WRITE  out  1  echo of REQ_WRITE.
- RAM_ADDR  out  ADDR_WIDTH  to RAM ADDR.
- RAM_DI  out  DATA_WIDTH  to RAM DI.
- RAM_WE  out  1  to RAM WE.
- RAM_RE  out  1  to RAM RE.
- RAM_EN  out  1  to RAM EN.
- RAM_DO  in  DATA_WIDTH  from RAM DO.
- RAM_DO_VALID  in  1  from RAM DO_VALID.

Behaviour:
- One clock domain (CLK). RST_N is asynchronous, active-low.
- Reset: state=IDLE, RSP_VALID=0, RSP_RDATA=0, RSP_WRITE=0, internal registers=0. RAM_EN/WE/RE are 0 during reset.
- Reset mid-operation: the in-flight request is discarded. An RMW caught in RMW_RD never writes the RAM.
- States: IDLE, RD_WAIT, RMW_RD, RMW_WR.
- REQ_READY = RST_N && state==IDLE && (!RSP_VALID || RSP_READY). Accept = REQ_VALID && REQ_READY.
- At most one request is outstanding.
- RAM_* outputs are combinational from state and accept. RAM_* = 0 in every cycle not listed below.
- Read accept (IDLE):
  - Same cycle: RAM_EN=1, RAM_RE=1, RAM_ADDR=REQ_ADDR.
  - Next state RD_WAIT.
- RD_WAIT:
  - Hold until RAM_DO_VALID=1; stalls of any length are tolerated.
  - On DO_VALID: register RSP_RDATA=RAM_DO, RSP_WRITE=0, RSP_VALID=1; go to IDLE.
  - Read latency: accept at cycle 0 gives RSP_VALID at cycle 2.
- Full write (all strobes 1):
  - Same cycle: RAM_EN=1, RAM_WE=1, RAM_RE=0, RAM_DI=REQ_WDATA.
  - Next cycle: RSP_VALID=1, RSP_RDATA=REQ_WDATA, RSP_WRITE=1. State stays IDLE.
- Zero-strobe write: no RAM access. Next cycle RSP_VALID=1, RSP_RDATA=0, RSP_WRITE=1.
- Partial write (some but not all strobes set):
  - Accept cycle: issue a read as for a read request; latch ADDR, WDATA and STRB; go to RMW_RD.
  - RMW_RD: on RAM_DO_VALID, register merged word: byte i = STRB[i] ? WDATA byte i : RAM_DO byte i. Go to RMW_WR.
  - RMW_WR: RAM_EN=1, RAM_WE=1, RAM_RE=0, RAM_ADDR=latched address, RAM_DI=merged word.
  - Next cycle: RSP_VALID=1, RSP_RDATA=merged word, RSP_WRITE=1. State IDLE.
  - Latency: accept at cycle 0 gives RSP_VALID at cycle 3.
- Response holding: RSP_VALID, RSP_RDATA and RSP_WRITE stay stable until RSP_VALID && RSP_READY.
- RSP_VALID falls after that handshake unless a new response is loaded in the same cycle.
- Back-to-back: a new request may be accepted in the same cycle the pending response handshakes. Best throughput is 1 read per 2 cycles or 1 full write per cycle.
- RAM_DO_VALID arriving in IDLE is ignored.
- Atomicity of RMW against writes from the RAM's other port is not guaranteed; system software owns that.

Test Plan:
- Read: RAM preloaded with addr 5 = 0xDEADBEEF; read addr 5 -> RAM_EN=RE=1 at cycle 0; RSP_VALID=1 with RSP_RDATA=0xDEADBEEF at cycle 2; REQ_READY=0 in cycle 1.
- Full write then read: write addr 3 data 0x12345678, strb 0xF -> RAM_WE=1 at cycle 0, RSP at cycle 1 with RSP_RDATA=0x12345678 and RSP_WRITE=1; a following read of addr 3 returns 0x12345678.
- RMW: addr 7 = 0xAABBCCDD; write data 0x11223344, strb 0b0101 -> RAM_WE only at cycle 2 with DI=0xAA22CC44; RSP at cycle 3 with RDATA=0xAA22CC44; a later read returns 0xAA22CC44.
- Backpressure: RSP_READY=0 for 5 cycles after a read response -> RSP_RDATA stable, REQ_READY=0, no RAM_EN; set RSP_READY=1 with REQ_VALID=1 -> new request accepted in the handshake cycle.
- Zero strobe: write strb 0 to addr 9 (preloaded 0x5A5A5A5A) -> RAM_EN never asserted; RSP_RDATA=0 next cycle; addr 9 still reads 0x5A5A5A5A.
- Reset mid-RMW: drop RST_N while in RMW_RD -> RSP_VALID=0 and RAM outputs 0 immediately; no write occurs; after release REQ_READY=1 and target word unchanged.

Source files
------------

// File: rtl/bram_rmw_requester.sv
// Request/response front end for one port of a one-cycle dual-port block RAM.
// Partial-strobe writes are done as read, byte-merge, then full-word write.
module bram_rmw_requester #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic                    REQ_WRITE,
    input  logic [DATA_WIDTH-1:0]   REQ_WDATA,
    input  logic [DATA_WIDTH/8-1:0] REQ_STRB,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [DATA_WIDTH-1:0]   RSP_RDATA,
    output logic                    RSP_WRITE,
    output logic [ADDR_WIDTH-1:0]   RAM_ADDR,
    output logic [DATA_WIDTH-1:0]   RAM_DI,
    output logic                    RAM_WE,
    output logic                    RAM_RE,
    output logic                    RAM_EN,
    input  logic [DATA_WIDTH-1:0]   RAM_DO,
    input  logic                    RAM_DO_VALID
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RMW_RD  = 2'd2;
    localparam logic [1:0] RMW_WR  = 2'd3;

    logic [1:0]            state_q,     state_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0] strb_q,      strb_d;
    logic [DATA_WIDTH-1:0] merged_q,    merged_d;

    logic                  accept;
    logic                  strb_full;
    logic                  strb_none;
    logic [DATA_WIDTH-1:0] merged_w;

    assign REQ_READY = RST_N && (state_q == IDLE) && (!rsp_valid_q || RSP_READY);
    assign accept    = REQ_VALID && REQ_READY;
    assign strb_full = &REQ_STRB;
    assign strb_none = ~|REQ_STRB;

    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_WRITE = rsp_write_q;

    // Strobed bytes come from the latched write data, the rest from the RAM word.
    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_merge
            assign merged_w[gi*8 +: 8] = strb_q[gi] ? wdata_q[gi*8 +: 8] : RAM_DO[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_write_d = rsp_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        merged_d    = merged_q;

        if (rsp_valid_q && RSP_READY) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!REQ_WRITE) begin
                        state_d = RD_WAIT;
                    end else if (strb_full) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = REQ_WDATA;
                        rsp_write_d = 1'b1;
                    end else if (strb_none) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_write_d = 1'b1;
                    end else begin
                        addr_d  = REQ_ADDR;
                        wdata_d = REQ_WDATA;
                        strb_d  = REQ_STRB;
                        state_d = RMW_RD;
                    end
                end
            end
            RD_WAIT: begin
                if (RAM_DO_VALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = RAM_DO;
                    rsp_write_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            RMW_RD: begin
                if (RAM_DO_VALID) begin
                    merged_d = merged_w;
                    state_d  = RMW_WR;
                end
            end
            RMW_WR: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = merged_q;
                rsp_write_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM port is driven only in the accept cycle and in the RMW write-back cycle.
    always_comb begin
        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_RE   = 1'b0;
        RAM_ADDR = '0;
        RAM_DI   = '0;
        if (accept) begin
            if (!REQ_WRITE || !(strb_full || strb_none)) begin
                RAM_EN   = 1'b1;
                RAM_RE   = 1'b1;
                RAM_ADDR = REQ_ADDR;
            end else if (strb_full) begin
                RAM_EN   = 1'b1;
                RAM_WE   = 1'b1;
                RAM_ADDR = REQ_ADDR;
                RAM_DI   = REQ_WDATA;
            end
        end else if (state_q == RMW_WR && RST_N) begin
            RAM_EN   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_ADDR = addr_q;
            RAM_DI   = merged_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            merged_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_write_q <= rsp_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            merged_q    <= merged_d;
        end
    end

endmodule

// File: tb/tb_bram_rmw_requester.sv
// Directed bench for bram_rmw_requester with a behavioural one-cycle RAM attached.
module tb_bram_rmw_requester;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic          ram_we;
    logic          ram_re;
    logic          ram_en;
    logic [DW-1:0] ram_do;
    logic          ram_do_valid;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bram_rmw_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_ADDR(req_addr),
        .REQ_WRITE(req_write), .REQ_WDATA(req_wdata), .REQ_STRB(req_strb),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
        .RSP_WRITE(rsp_write),
        .RAM_ADDR(ram_addr), .RAM_DI(ram_di), .RAM_WE(ram_we), .RAM_RE(ram_re),
        .RAM_EN(ram_en), .RAM_DO(ram_do), .RAM_DO_VALID(ram_do_valid)
    );

    // One-cycle RAM: read data and its valid appear the cycle after EN&RE.
    always @(posedge clk) begin
        ram_do_valid <= 1'b0;
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            if (ram_re) begin
                ram_do       <= mem[ram_addr];
                ram_do_valid <= 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output bit ok);
        ok   = 1'b0;
        data = '0;
        step();
        req_valid = 1'b1; req_addr = addr; req_write = 1'b0; req_strb = '0; req_wdata = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
            step();
        end
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                data = rsp_rdata;
                ok   = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_strb = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b rdata=%h write=%b, required 0 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_write);
        end
        checks++;
        if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0) begin
            errors++;
            $display("FAIL reset_ram: en=%b we=%b re=%b, required 0 0 0", ram_en, ram_we, ram_re);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
        $display("reset: ready=%b rsp_valid=%b", req_ready, rsp_valid);
    endtask

    task automatic test_read();
        mem[5] = 32'hDEADBEEF;
        step();
        req_valid = 1'b1; req_addr = 10'd5; req_write = 1'b0; req_strb = '0; req_wdata = '0;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1 || ram_re !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 10'd5) begin
            errors++;
            $display("FAIL read_issue: en=%b re=%b we=%b addr=%0d, required 1 1 0 5",
                     ram_en, ram_re, ram_we, ram_addr);
        end
        step();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL read_cycle1: ready=%b rsp_valid=%b en=%b, required 0 0 0",
                     req_ready, rsp_valid, ram_en);
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_write !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp: valid=%b rdata=%h write=%b, required 1 deadbeef 0",
                     rsp_valid, rsp_rdata, rsp_write);
        end
        $display("read addr=5 rdata=%h", rsp_rdata);
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp_drop: valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_full_write();
        logic [DW-1:0] rd;
        bit            ok;
        step();
        req_valid = 1'b1; req_addr = 10'd3; req_write = 1'b1;
        req_wdata = 32'h12345678; req_strb = 4'hF;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== 10'd3 || ram_di !== 32'h12345678) begin
            errors++;
            $display("FAIL full_write_issue: en=%b we=%b re=%b addr=%0d di=%h, required 1 1 0 3 12345678",
                     ram_en, ram_we, ram_re, ram_addr, ram_di);
        end
        step();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_write !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_write_rsp: valid=%b rdata=%h write=%b ready=%b, required 1 12345678 1 1",
                     rsp_valid, rsp_rdata, rsp_write, req_ready);
        end
        $display("write addr=3 wdata=12345678 strb=f rsp=%h", rsp_rdata);
        do_read(10'd3, rd, ok);
        checks++;
        if (!ok || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL full_write_readback: ok=%0d rdata=%h, required 1 12345678", ok, rd);
        end
        $display("read addr=3 rdata=%h", rd);
    endtask

    task automatic test_rmw();
        logic [DW-1:0] rd;
        bit            ok;
        mem[7] = 32'hAABBCCDD;
        step();
        req_valid = 1'b1; req_addr = 10'd7; req_write = 1'b1;
        req_wdata = 32'h11223344; req_strb = 4'b0101;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1 || ram_re !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 10'd7) begin
            errors++;
            $display("FAIL rmw_read_issue: en=%b re=%b we=%b addr=%0d, required 1 1 0 7",
                     ram_en, ram_re, ram_we, ram_addr);
        end
        step();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b0 || ram_we !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmw_cycle1: en=%b we=%b rsp_valid=%b, required 0 0 0", ram_en, ram_we, rsp_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== 10'd7 || ram_di !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL rmw_write_issue: en=%b we=%b re=%b addr=%0d di=%h, required 1 1 0 7 aa22cc44",
                     ram_en, ram_we, ram_re, ram_addr, ram_di);
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hAA22CC44 || rsp_write !== 1'b1 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL rmw_rsp: valid=%b rdata=%h write=%b en=%b, required 1 aa22cc44 1 0",
                     rsp_valid, rsp_rdata, rsp_write, ram_en);
        end
        $display("rmw addr=7 wdata=11223344 strb=5 rsp=%h", rsp_rdata);
        do_read(10'd7, rd, ok);
        checks++;
        if (!ok || rd !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL rmw_readback: ok=%0d rdata=%h, required 1 aa22cc44", ok, rd);
        end
        $display("read addr=7 rdata=%h", rd);
    endtask

    task automatic test_backpressure();
        bit got;
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 10'd5; req_write = 1'b0; req_strb = '0;
        step();
        req_valid = 1'b0;
        step();
        // Response now visible; queue a read of addr 3 behind it.
        req_valid = 1'b1; req_addr = 10'd3; req_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 || ram_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b rdata=%h ready=%b en=%b, required 1 deadbeef 0 0",
                         i, rsp_valid, rsp_rdata, req_ready, ram_en);
            end
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || ram_en !== 1'b1 || ram_re !== 1'b1 || ram_addr !== 10'd3) begin
            errors++;
            $display("FAIL bp_handshake_accept: ready=%b en=%b re=%b addr=%0d, required 1 1 1 3",
                     req_ready, ram_en, ram_re, ram_addr);
        end
        step();
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!got || rsp_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL bp_second_rsp: got=%0d rdata=%h, required 1 12345678", got, rsp_rdata);
        end
        $display("backpressure held 5 cycles, follow-up read addr=3 rdata=%h", rsp_rdata);
    endtask

    task automatic test_zero_strobe();
        logic [DW-1:0] rd;
        bit            ok;
        mem[9] = 32'h5A5A5A5A;
        step();
        req_valid = 1'b1; req_addr = 10'd9; req_write = 1'b1;
        req_wdata = 32'hFFFFFFFF; req_strb = 4'h0;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b0 || ram_we !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_strb_issue: en=%b we=%b ready=%b, required 0 0 1", ram_en, ram_we, req_ready);
        end
        step();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_write !== 1'b1 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL zero_strb_rsp: valid=%b rdata=%h write=%b en=%b, required 1 00000000 1 0",
                     rsp_valid, rsp_rdata, rsp_write, ram_en);
        end
        $display("write addr=9 strb=0 rsp=%h", rsp_rdata);
        do_read(10'd9, rd, ok);
        checks++;
        if (!ok || rd !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL zero_strb_readback: ok=%0d rdata=%h, required 1 5a5a5a5a", ok, rd);
        end
        $display("read addr=9 rdata=%h", rd);
    endtask

    task automatic test_back_to_back();
        step();
        req_valid = 1'b1; req_addr = 10'd20; req_write = 1'b1;
        req_wdata = 32'hCAFE0001; req_strb = 4'hF;
        step();
        req_addr = 10'd21; req_wdata = 32'hCAFE0002;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE0001 || ram_we !== 1'b1 || ram_addr !== 10'd21) begin
            errors++;
            $display("FAIL b2b_first: ready=%b valid=%b rdata=%h we=%b addr=%0d, required 1 1 cafe0001 1 21",
                     req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr);
        end
        step();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE0002 || mem[20] !== 32'hCAFE0001 || mem[21] !== 32'hCAFE0002) begin
            errors++;
            $display("FAIL b2b_second: valid=%b rdata=%h mem20=%h mem21=%h, required 1 cafe0002 cafe0001 cafe0002",
                     rsp_valid, rsp_rdata, mem[20], mem[21]);
        end
        $display("back-to-back writes addr=20,21 rsp=%h", rsp_rdata);
    endtask

    task automatic test_reset_mid_rmw();
        mem[11] = 32'h01020304;
        step();
        req_valid = 1'b1; req_addr = 10'd11; req_write = 1'b1;
        req_wdata = 32'hFFFFFFFF; req_strb = 4'b0001;
        step();
        req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_rmw_outputs: valid=%b en=%b we=%b re=%b ready=%b, required 0 0 0 0 0",
                     rsp_valid, ram_en, ram_we, ram_re, req_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_rmw_ready: got %b, required 1", req_ready);
        end
        repeat (3) step();
        checks++;
        if (mem[11] !== 32'h01020304) begin
            errors++;
            $display("FAIL rst_mid_rmw_mem: mem11=%h, required 01020304", mem[11]);
        end
        $display("reset during rmw addr=11 mem=%h", mem[11]);
    endtask

    initial begin
        ram_do       = '0;
        ram_do_valid = 1'b0;
        test_reset();
        test_read();
        test_full_write();
        test_rmw();
        test_backpressure();
        test_zero_strobe();
        test_back_to_back();
        test_reset_mid_rmw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
